ex_mem_stage: RTL and testbench

- Execute stage plus EX/MEM pipeline register; consumes the ex_* bundle from the ID/EX register and produces the mem_* bundle for the memory stage.
- Single-cycle ALU for all ops except MUL. MUL runs on an iterative shift-add multiplier FSM.
- Asserts ex_busy to freeze PC and IF/ID, and to bubble ID/EX, while a MUL is in flight.

---
 rtl/ex_mem_stage_pkg.sv | 42 ++++
 rtl/ex_mem_stage_if.sv | 56 +++++
 rtl/ex_mem_stage_iterative_multiplier.sv | 101 ++++++++++
 rtl/ex_mem_stage.sv | 116 +++++++++++
 tb/tb_ex_mem_stage.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/ex_mem_stage_pkg.sv
// Shared definitions for the execute stage: datapath widths, ALU op codes,
// the multiplier FSM state type and the EX/MEM register bundle.
package ex_mem_stage_pkg;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_NOR = 4'd5;
    localparam logic [3:0] ALU_SLT = 4'd6;
    localparam logic [3:0] ALU_SLL = 4'd7;
    localparam logic [3:0] ALU_SRL = 4'd8;
    localparam logic [3:0] ALU_SRA = 4'd9;
    localparam logic [3:0] ALU_LUI = 4'd10;
    localparam logic [3:0] ALU_MUL = 4'd11;

    typedef enum logic {
        MUL_IDLE = 1'b0,
        MUL_BUSY = 1'b1
    } mul_state_e;

    // Contents of the EX/MEM pipeline register; all-zero is a bubble.
    typedef struct packed {
        logic [DATA_W-1:0]     instruction;
        logic [DATA_W-1:0]     alu_output;
        logic [DATA_W-1:0]     store_data;
        logic                  write_register;
        logic [REG_ADDR_W-1:0] write_address;
        logic                  mem_to_register;
        logic                  write_memory;
    } ex_mem_t;

    // Number of multiplier iterations for a given number of bits per cycle.
    function automatic int mul_iterations(input int unsigned bits_per_cycle);
        return DATA_W / int'(bits_per_cycle);
    endfunction

endpackage

// File: rtl/ex_mem_stage_if.sv
// ID/EX -> EX -> EX/MEM bundle. The master side (ID/EX register, hazard
// logic, memory stage) drives ex_* and observes ex_busy and mem_*; the
// execute stage is the slave.
interface ex_mem_stage_if;
    import ex_mem_stage_pkg::*;

    logic [DATA_W-1:0]     ex_instruction;
    logic [DATA_W-1:0]     ex_shiftAmount;
    logic [DATA_W-1:0]     ex_immediate;
    logic [DATA_W-1:0]     ex_registerRsOrPc_4;
    logic [DATA_W-1:0]     ex_registerRtOrZero;
    logic [3:0]            ex_aluOperation;
    logic                  ex_shouldAluUseShiftAmountElseRegisterRsOrPc_4;
    logic                  ex_shouldAluUseImmeidateElseRegisterRtOrZero;
    logic                  ex_shouldWriteRegister;
    logic [REG_ADDR_W-1:0] ex_registerWriteAddress;
    logic                  ex_shouldWriteMemoryElseAluOutputToRegister;
    logic                  ex_shouldWriteMemory;

    logic                  ex_busy;

    logic [DATA_W-1:0]     mem_instruction;
    logic [DATA_W-1:0]     mem_aluOutput;
    logic [DATA_W-1:0]     mem_storeData;
    logic                  mem_shouldWriteRegister;
    logic [REG_ADDR_W-1:0] mem_registerWriteAddress;
    logic                  mem_shouldWriteMemoryElseAluOutputToRegister;
    logic                  mem_shouldWriteMemory;

    modport master (
        output ex_instruction, ex_shiftAmount, ex_immediate, ex_registerRsOrPc_4,
               ex_registerRtOrZero, ex_aluOperation,
               ex_shouldAluUseShiftAmountElseRegisterRsOrPc_4,
               ex_shouldAluUseImmeidateElseRegisterRtOrZero,
               ex_shouldWriteRegister, ex_registerWriteAddress,
               ex_shouldWriteMemoryElseAluOutputToRegister, ex_shouldWriteMemory,
        input  ex_busy,
               mem_instruction, mem_aluOutput, mem_storeData, mem_shouldWriteRegister,
               mem_registerWriteAddress, mem_shouldWriteMemoryElseAluOutputToRegister,
               mem_shouldWriteMemory
    );

    modport slave (
        input  ex_instruction, ex_shiftAmount, ex_immediate, ex_registerRsOrPc_4,
               ex_registerRtOrZero, ex_aluOperation,
               ex_shouldAluUseShiftAmountElseRegisterRsOrPc_4,
               ex_shouldAluUseImmeidateElseRegisterRtOrZero,
               ex_shouldWriteRegister, ex_registerWriteAddress,
               ex_shouldWriteMemoryElseAluOutputToRegister, ex_shouldWriteMemory,
        output ex_busy,
               mem_instruction, mem_aluOutput, mem_storeData, mem_shouldWriteRegister,
               mem_registerWriteAddress, mem_shouldWriteMemoryElseAluOutputToRegister,
               mem_shouldWriteMemory
    );

endinterface

// File: rtl/ex_mem_stage_iterative_multiplier.sv
// Iterative shift-add multiplier producing the low DATA_W bits of a*b.
// BITS_PER_CYCLE multiplier bits are retired per BUSY cycle (1/2/4/8).
//
// state    | meaning
// ---------+-------------------------------------------------------------
// MUL_IDLE | waiting; start_i loads operands, clears product and counter
// MUL_BUSY | one iteration per cycle; last iteration raises done_o
//
// product_o is the next-state product, so in the done_o cycle it already
// holds the completed result and can be captured at the same edge.
module iterative_multiplier
    import ex_mem_stage_pkg::*;
#(
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] product_o
);

    localparam int ITERATIONS = mul_iterations(BITS_PER_CYCLE);
    localparam int CNT_W      = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(ITERATIONS - 1);

    mul_state_e        state_q, state_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] product_q, product_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] partial;

    // Sum of the shifted multiplicand copies selected by the low multiplier bits.
    always_comb begin
        partial = '0;
        for (int j = 0; j < int'(BITS_PER_CYCLE); j++) begin
            if (b_q[j]) begin
                partial = partial + (a_q << j);
            end
        end
    end

    // Next-state and output logic of the multiplier FSM.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        product_d = product_q;
        count_d   = count_q;
        busy_o    = 1'b0;
        done_o    = 1'b0;
        case (state_q)
            MUL_IDLE: begin
                if (start_i) begin
                    a_d       = a_i;
                    b_d       = b_i;
                    product_d = '0;
                    count_d   = '0;
                    state_d   = MUL_BUSY;
                end
            end
            MUL_BUSY: begin
                product_d = product_q + partial;
                a_d       = a_q << BITS_PER_CYCLE;
                b_d       = b_q >> BITS_PER_CYCLE;
                count_d   = count_q + CNT_W'(1);
                if (count_q == LAST_COUNT) begin
                    done_o  = 1'b1;
                    state_d = MUL_IDLE;
                end else begin
                    busy_o = 1'b1;
                end
            end
            default: state_d = MUL_IDLE;
        endcase
    end

    assign product_o = product_d;

    // State, operand shift registers, product and iteration counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= MUL_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            product_q <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            product_q <= product_d;
            count_q   <= count_d;
        end
    end

endmodule

// File: rtl/ex_mem_stage.sv
// Execute stage plus EX/MEM pipeline register. Single-cycle ALU for every op
// except MUL, which runs on the iterative multiplier while ex_busy stalls
// the front of the pipe. The EX/MEM register loads bubbles until the product
// is ready, so a MUL writes its destination exactly once.
module ex_mem_stage
    import ex_mem_stage_pkg::*;
#(
    parameter int unsigned MUL_BITS_PER_CYCLE = 1
) (
    input logic           clk,
    input logic           rst,
    ex_mem_stage_if.slave bus
);

    logic [DATA_W-1:0] operand_a;
    logic [DATA_W-1:0] operand_b;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] mul_product;
    logic              is_mul;
    logic              mul_idle;
    logic              mul_busy;
    logic              mul_done;
    ex_mem_t           live_bundle;
    ex_mem_t           ex_mem_q, ex_mem_d;
    ex_mem_t           saved_q, saved_d;

    assign operand_a = bus.ex_shouldAluUseShiftAmountElseRegisterRsOrPc_4 ?
                       bus.ex_shiftAmount : bus.ex_registerRsOrPc_4;
    assign operand_b = bus.ex_shouldAluUseImmeidateElseRegisterRtOrZero ?
                       bus.ex_immediate : bus.ex_registerRtOrZero;

    // Single-cycle ALU; MUL and the unused codes 12-15 yield zero here.
    always_comb begin
        alu_result = '0;
        case (bus.ex_aluOperation)
            ALU_ADD: alu_result = operand_a + operand_b;
            ALU_SUB: alu_result = operand_a - operand_b;
            ALU_AND: alu_result = operand_a & operand_b;
            ALU_OR:  alu_result = operand_a | operand_b;
            ALU_XOR: alu_result = operand_a ^ operand_b;
            ALU_NOR: alu_result = ~(operand_a | operand_b);
            ALU_SLT: alu_result = {{(DATA_W-1){1'b0}}, ($signed(operand_a) < $signed(operand_b))};
            ALU_SLL: alu_result = operand_b << operand_a[4:0];
            ALU_SRL: alu_result = operand_b >> operand_a[4:0];
            ALU_SRA: alu_result = $unsigned($signed(operand_b) >>> operand_a[4:0]);
            ALU_LUI: alu_result = {operand_b[15:0], 16'h0000};
            default: alu_result = '0;
        endcase
    end

    assign is_mul   = (bus.ex_aluOperation == ALU_MUL);
    assign mul_idle = !(mul_busy || mul_done);

    iterative_multiplier #(
        .BITS_PER_CYCLE(MUL_BITS_PER_CYCLE)
    ) u_mul (
        .clk       (clk),
        .rst       (rst),
        .start_i   (mul_idle && is_mul),
        .a_i       (operand_a),
        .b_i       (operand_b),
        .busy_o    (mul_busy),
        .done_o    (mul_done),
        .product_o (mul_product)
    );

    // The start cycle already stalls; the final iteration releases the stall.
    assign bus.ex_busy = mul_busy || (mul_idle && is_mul);

    assign live_bundle = '{
        instruction:     bus.ex_instruction,
        alu_output:      alu_result,
        store_data:      bus.ex_registerRtOrZero,
        write_register:  bus.ex_shouldWriteRegister,
        write_address:   bus.ex_registerWriteAddress,
        mem_to_register: bus.ex_shouldWriteMemoryElseAluOutputToRegister,
        write_memory:    bus.ex_shouldWriteMemory
    };

    // EX/MEM next value: live ALU result, bubble while a MUL runs, or the
    // saved MUL bundle with the finished product on the last iteration.
    always_comb begin
        ex_mem_d = '0;
        saved_d  = saved_q;
        if (mul_done) begin
            ex_mem_d            = saved_q;
            ex_mem_d.alu_output = mul_product;
        end else if (mul_idle) begin
            if (is_mul) begin
                saved_d = live_bundle;
            end else begin
                ex_mem_d = live_bundle;
            end
        end
    end

    // EX/MEM register and the held MUL control bundle.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_mem_q <= '0;
            saved_q  <= '0;
        end else begin
            ex_mem_q <= ex_mem_d;
            saved_q  <= saved_d;
        end
    end

    assign bus.mem_instruction                              = ex_mem_q.instruction;
    assign bus.mem_aluOutput                                = ex_mem_q.alu_output;
    assign bus.mem_storeData                                = ex_mem_q.store_data;
    assign bus.mem_shouldWriteRegister                      = ex_mem_q.write_register;
    assign bus.mem_registerWriteAddress                     = ex_mem_q.write_address;
    assign bus.mem_shouldWriteMemoryElseAluOutputToRegister = ex_mem_q.mem_to_register;
    assign bus.mem_shouldWriteMemory                        = ex_mem_q.write_memory;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage. Two instances share the stimulus: one
// with a 1-bit/cycle multiplier and one with 4 bits/cycle; sel picks which
// one the scoreboard and busy checks observe. Every driven cycle pushes the
// expected EX/MEM contents for the following edge.
module tb_ex_mem_stage;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] alu;
        logic [31:0] store;
        logic        wr;
        logic [4:0]  waddr;
        logic        m2r;
        logic        wm;
    } mem_t;

    typedef struct {
        mem_t v;
        int   tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sel = 1'b0;
    int   errors  = 0;
    int   checks  = 0;
    int   tag     = 0;
    int   busy_hi = 0;
    exp_t exp_q[$];
    mem_t got;
    logic got_busy;

    ex_mem_stage_if if1();
    ex_mem_stage_if if4();

    ex_mem_stage #(.MUL_BITS_PER_CYCLE(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));
    ex_mem_stage #(.MUL_BITS_PER_CYCLE(4)) u_dut4 (.clk(clk), .rst(rst), .bus(if4));

    always #5 clk = ~clk;

    assign got = sel ?
        {if4.mem_instruction, if4.mem_aluOutput, if4.mem_storeData, if4.mem_shouldWriteRegister,
         if4.mem_registerWriteAddress, if4.mem_shouldWriteMemoryElseAluOutputToRegister,
         if4.mem_shouldWriteMemory} :
        {if1.mem_instruction, if1.mem_aluOutput, if1.mem_storeData, if1.mem_shouldWriteRegister,
         if1.mem_registerWriteAddress, if1.mem_shouldWriteMemoryElseAluOutputToRegister,
         if1.mem_shouldWriteMemory};
    assign got_busy = sel ? if4.ex_busy : if1.ex_busy;

    function automatic mem_t mk(input logic [31:0] instr, input logic [31:0] alu,
                                input logic [31:0] store, input logic wr,
                                input logic [4:0] waddr, input logic m2r, input logic wm);
        mem_t m;
        m.instr = instr; m.alu = alu; m.store = store;
        m.wr = wr; m.waddr = waddr; m.m2r = m2r; m.wm = wm;
        return m;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic apply(input logic [31:0] instr, input logic [31:0] rs, input logic [31:0] rt,
                         input logic [31:0] shamt, input logic [31:0] imm, input logic [3:0] op,
                         input logic asel, input logic bsel, input logic wr,
                         input logic [4:0] waddr, input logic m2r, input logic wm);
        if1.ex_instruction = instr;       if4.ex_instruction = instr;
        if1.ex_registerRsOrPc_4 = rs;     if4.ex_registerRsOrPc_4 = rs;
        if1.ex_registerRtOrZero = rt;     if4.ex_registerRtOrZero = rt;
        if1.ex_shiftAmount = shamt;       if4.ex_shiftAmount = shamt;
        if1.ex_immediate = imm;           if4.ex_immediate = imm;
        if1.ex_aluOperation = op;         if4.ex_aluOperation = op;
        if1.ex_shouldAluUseShiftAmountElseRegisterRsOrPc_4 = asel;
        if4.ex_shouldAluUseShiftAmountElseRegisterRsOrPc_4 = asel;
        if1.ex_shouldAluUseImmeidateElseRegisterRtOrZero = bsel;
        if4.ex_shouldAluUseImmeidateElseRegisterRtOrZero = bsel;
        if1.ex_shouldWriteRegister = wr;  if4.ex_shouldWriteRegister = wr;
        if1.ex_registerWriteAddress = waddr; if4.ex_registerWriteAddress = waddr;
        if1.ex_shouldWriteMemoryElseAluOutputToRegister = m2r;
        if4.ex_shouldWriteMemoryElseAluOutputToRegister = m2r;
        if1.ex_shouldWriteMemory = wm;    if4.ex_shouldWriteMemory = wm;
    endtask

    task automatic bubble();
        apply('0, '0, '0, '0, '0, 4'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    // Queue the EX/MEM contents expected after the next edge, then check ex_busy now.
    task automatic commit(input mem_t e, input logic busy_exp);
        exp_t x;
        x.v = e;
        x.tag = tag;
        exp_q.push_back(x);
        #1;
        checks++;
        if (got_busy === 1'b1) busy_hi++;
        if (got_busy !== busy_exp) begin
            errors++;
            $display("FAIL ex_busy[%0d]: got %b expected %b", tag, got_busy, busy_exp);
        end
        tag++;
    endtask

    // Monitor: after every edge, compare EX/MEM against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (got !== e.v) begin
                    errors++;
                    $display("FAIL mem_bundle[%0d]: got instr=%h alu=%h store=%h wr=%b waddr=%0d m2r=%b wm=%b expected instr=%h alu=%h store=%h wr=%b waddr=%0d m2r=%b wm=%b",
                             e.tag, got.instr, got.alu, got.store, got.wr, got.waddr, got.m2r, got.wm,
                             e.v.instr, e.v.alu, e.v.store, e.v.wr, e.v.waddr, e.v.m2r, e.v.wm);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin
        bubble();
        // reset
        cyc(); rst = 1'b1; bubble(); commit('0, 1'b0);
        cyc(); rst = 1'b0;

        // single-cycle ops (k=1 instance)
        apply(32'h00A71820, 32'd5, 32'd7, 0, 0, 4'd0, 0, 0, 1, 5'd3, 0, 0);
        commit(mk(32'h00A71820, 32'd12, 32'd7, 1, 5'd3, 0, 0), 1'b0);
        cyc(); apply(32'h00041903, 32'h55, 32'hF0000000, 32'd4, 0, 4'd9, 1, 0, 1, 5'd8, 0, 0);
        commit(mk(32'h00041903, 32'hFF000000, 32'hF0000000, 1, 5'd8, 0, 0), 1'b0);
        cyc(); apply(32'h0001482A, 32'hFFFFFFFF, 32'd1, 0, 0, 4'd6, 0, 0, 1, 5'd9, 0, 0);
        commit(mk(32'h0001482A, 32'd1, 32'd1, 1, 5'd9, 0, 0), 1'b0);
        cyc(); apply(32'h0002482A, 32'd1, 32'hFFFFFFFF, 0, 0, 4'd6, 0, 0, 1, 5'd9, 0, 0);
        commit(mk(32'h0002482A, 32'd0, 32'hFFFFFFFF, 1, 5'd9, 0, 0), 1'b0);
        cyc(); apply(32'h00A71822, 32'd5, 32'd7, 0, 0, 4'd1, 0, 0, 1, 5'd4, 0, 0);
        commit(mk(32'h00A71822, 32'hFFFFFFFE, 32'd7, 1, 5'd4, 0, 0), 1'b0);
        cyc(); apply(32'h00A71826, 32'hFF00FF00, 32'h0F0F0F0F, 0, 0, 4'd4, 0, 0, 1, 5'd5, 0, 0);
        commit(mk(32'h00A71826, 32'hF00FF00F, 32'h0F0F0F0F, 1, 5'd5, 0, 0), 1'b0);
        cyc(); apply(32'h00000827, 0, 0, 0, 0, 4'd5, 0, 0, 1, 5'd1, 0, 0);
        commit(mk(32'h00000827, 32'hFFFFFFFF, 32'd0, 1, 5'd1, 0, 0), 1'b0);
        cyc(); apply(32'h000117C0, 32'h9, 32'd1, 32'd31, 0, 4'd7, 1, 0, 1, 5'd2, 0, 0);
        commit(mk(32'h000117C0, 32'h80000000, 32'd1, 1, 5'd2, 0, 0), 1'b0);
        cyc(); apply(32'h00011902, 32'h9, 32'hF0000000, 32'd4, 0, 4'd8, 1, 0, 1, 5'd6, 0, 0);
        commit(mk(32'h00011902, 32'h0F000000, 32'hF0000000, 1, 5'd6, 0, 0), 1'b0);
        cyc(); apply(32'h3C011234, 32'h77, 32'hAAAA, 0, 32'h1234, 4'd10, 0, 1, 1, 5'd1, 0, 0);
        commit(mk(32'h3C011234, 32'h12340000, 32'hAAAA, 1, 5'd1, 0, 0), 1'b0);
        cyc(); apply(32'h00A71824, 32'hF0F0, 32'hFF00, 0, 0, 4'd2, 0, 0, 1, 5'd7, 0, 0);
        commit(mk(32'h00A71824, 32'hF000, 32'hFF00, 1, 5'd7, 0, 0), 1'b0);
        cyc(); apply(32'h00A71825, 32'hF0F0, 32'hFF00, 0, 0, 4'd3, 0, 0, 1, 5'd7, 0, 0);
        commit(mk(32'h00A71825, 32'hFFF0, 32'hFF00, 1, 5'd7, 0, 0), 1'b0);
        cyc(); apply(32'hAC220008, 32'h100, 32'hDEADBEEF, 0, 32'd8, 4'd0, 0, 1, 0, 5'd0, 0, 1);
        commit(mk(32'hAC220008, 32'h108, 32'hDEADBEEF, 0, 5'd0, 0, 1), 1'b0);
        cyc(); apply(32'h0000000D, 32'd5, 32'd9, 0, 0, 4'd13, 0, 0, 1, 5'd2, 1, 0);
        commit(mk(32'h0000000D, 32'd0, 32'd9, 1, 5'd2, 1, 0), 1'b0);
        cyc(); bubble(); commit('0, 1'b0);

        // MUL 3 * 0xFFFFFFFF, k=1: 32 busy cycles, result on edge 33
        busy_hi = 0;
        cyc(); apply(32'h00434818, 32'd3, 32'hFFFFFFFF, 0, 0, 4'd11, 0, 0, 1, 5'd9, 0, 0);
        commit('0, 1'b1);
        for (int i = 0; i < 32; i++) begin
            cyc(); apply(32'h00221020, 32'd1, 32'd2, 0, 0, 4'd0, 0, 0, 1, 5'd4, 0, 0);
            commit((i == 31) ? mk(32'h00434818, 32'hFFFFFFFD, 32'hFFFFFFFF, 1, 5'd9, 0, 0) : mem_t'(0),
                   (i != 31));
        end
        cyc(); apply(32'h00221020, 32'd1, 32'd2, 0, 0, 4'd0, 0, 0, 1, 5'd4, 0, 0);
        commit(mk(32'h00221020, 32'd3, 32'd2, 1, 5'd4, 0, 0), 1'b0);
        checks++;
        if (busy_hi != 32) begin
            errors++;
            $display("FAIL busy_len_k1: got %0d cycles expected 32", busy_hi);
        end

        // reset at MUL iteration 10 aborts it with no write
        cyc(); apply(32'h00A65018, 32'd5, 32'd6, 0, 0, 4'd11, 0, 0, 1, 5'd10, 0, 0);
        commit('0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            cyc(); bubble(); commit('0, 1'b1);
        end
        cyc(); rst = 1'b1; commit('0, 1'b1);
        cyc(); rst = 1'b0;
        apply(32'h01422820, 32'd10, 32'd20, 0, 0, 4'd0, 0, 0, 1, 5'd5, 0, 0);
        commit(mk(32'h01422820, 32'd30, 32'd20, 1, 5'd5, 0, 0), 1'b0);
        cyc(); bubble(); commit('0, 1'b0);

        // k=4 instance: MUL 0x10000 * 0x10000, 8 busy cycles, result on edge 9
        cyc(); sel = 1'b1; rst = 1'b1; bubble(); commit('0, 1'b0);
        cyc(); rst = 1'b0;
        busy_hi = 0;
        apply(32'h00E73818, 32'h10000, 32'h10000, 0, 0, 4'd11, 0, 0, 1, 5'd7, 0, 0);
        commit('0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            cyc(); bubble();
            commit((i == 7) ? mk(32'h00E73818, 32'd0, 32'h10000, 1, 5'd7, 0, 0) : mem_t'(0),
                   (i != 7));
        end
        checks++;
        if (busy_hi != 8) begin
            errors++;
            $display("FAIL busy_len_k4: got %0d cycles expected 8", busy_hi);
        end

        // back-to-back MUL with immediate operand: 0x12345678 * 9
        cyc(); apply(32'h70096018, 32'h12345678, 32'hCAFEF00D, 0, 32'd9, 4'd11, 0, 1, 1, 5'd12, 0, 0);
        commit('0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            cyc(); bubble();
            commit((i == 7) ? mk(32'h70096018, 32'hA3D70A38, 32'hCAFEF00D, 1, 5'd12, 0, 0) : mem_t'(0),
                   (i != 7));
        end
        cyc(); apply(32'h00221020, 32'd40, 32'd2, 0, 0, 4'd0, 0, 0, 1, 5'd4, 0, 0);
        commit(mk(32'h00221020, 32'd42, 32'd2, 1, 5'd4, 0, 0), 1'b0);
        cyc(); bubble(); commit('0, 1'b0);

        cyc(); cyc(); cyc();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
